backup_ctrl: RTL
================

// Module: backup_ctrl
// PURPOSE
// - Checkpoint sequencer downstream of the per-register dirty trackers; consumes their 2-bit dirty codes.
// - On a checkpoint request: snapshots the dirty set, pulses Backup_en, copies each dirty register to NVM, then returns a per-register Backup_ack.
// - Sits between the register file (read port), the dirty trackers and the NVM write port.
// PARAMETERS
// - N_REGS   8       number of tracked registers (>=2)
// - DATA_W   32      register / NVM data width
// - NVM_AW   16      NVM word-address width
// - NVM_BASE 16'h0   NVM word address of register 0; register i is saved at NVM_BASE+i
// - IW       $clog2(N_REGS)  index width (derived, not overridable)
// PORTS
// - Clk          in   1            clock, rising edge
// - Rst_n        in   1            asynchronous reset, active-low
// - Ckpt_req     in   1            start checkpoint; sampled only in IDLE
// - Pwr_off      in   1            synchronous abort
// - Dirty_val    in   2*N_REGS     {reg N-1 .. reg 0} codes: 00 CLEAN, 01 DIRTY, 10 READ, 11 DIRTY_WR
// - Backup_en    out  N_REGS       one-cycle pulse per snapshotted register
// - Backup_ack   out  N_REGS       one-cycle pulse, at most one bit set per cycle
// - Rf_rd_addr   out  IW           register-file read index (combinational read)
// - Rf_rd_data   in   DATA_W       register-file read data
// - Nvm_req      out  1            NVM write request
// - Nvm_addr     out  NVM_AW       NVM write address
// - Nvm_wdata    out  DATA_W       NVM write data
// - Nvm_ack      in   1            NVM write accepted; may arrive in the same cycle as Nvm_req
// - Busy         out  1            high in every state except IDLE
// - Ckpt_done    out  1            one-cycle pulse on completion
// - Ckpt_abort   out  1            one-cycle pulse when Pwr_off kills an active checkpoint
// BEHAVIOUR
// - Reset (Rst_n=0): state IDLE; Mask, Idx, Resaved, data register cleared; all outputs 0.
// - FSM states: IDLE, SNAP, SCAN, RD, WR, ACK, DONE.
// - IDLE: Ckpt_req=1 -> SNAP. Requests while Busy are ignored, not queued.
// - SNAP (1 cycle):
//   - Mask[i] <= (Dirty_val[i]==01); Backup_en = next-value Mask (same cycle); Idx <= 0; -> SCAN.
//   - Registers at 00/10/11 are not snapshotted.
// - SCAN (1 cycle per index):
//   - Mask[Idx]=1 -> RD.
//   - Else if Idx==N_REGS-1 -> DONE.
//   - Else Idx++.
//   - Empty mask: DONE is reached N_REGS cycles after SNAP.
// - RD (1 cycle): Rf_rd_addr=Idx; data register <= Rf_rd_data; -> WR.
// - WR:
//   - Nvm_req=1, Nvm_addr=NVM_BASE+Idx (zero-extended; no wrap check), Nvm_wdata=data register.
//   - Request held stable until Nvm_ack.
//   - On Nvm_ack, if Dirty_val[Idx]==11 and Resaved==0: Resaved<=1, -> RD (one re-save).
//   - Otherwise on Nvm_ack -> ACK.
// - ACK (1 cycle): Backup_ack[Idx]=1; Mask[Idx]<=0; Resaved<=0.
//   - Idx==N_REGS-1 -> DONE; else Idx++, -> SCAN.
// - DONE: Ckpt_done=1 for one cycle; -> IDLE.
// - Pwr_off=1 in any non-IDLE state:
//   - Next state IDLE; Mask and Resaved cleared; Ckpt_abort=1 next cycle.
//   - Nvm_req, Backup_en, Backup_ack deasserted from the next cycle; no Ckpt_done.
// - Pwr_off=1 in IDLE: no effect; Ckpt_req is ignored that cycle.
// - Pwr_off has priority over Nvm_ack and Ckpt_req in the same cycle.
// - A tracker returning to 01/00 mid-sequence is not re-examined; only Mask drives the scan.
// - Writes after the re-save read are not captured; the core is halted during checkpoints.
// - Rst_n deasserting mid-operation: restart from IDLE.
// - Min latency per dirty register: RD+WR+ACK+SCAN = 4 cycles with same-cycle Nvm_ack.
// STRUCTURE
// - Shared package backup_pkg:
//   - dirty codes DIRTY_CLEAN=2'b00, DIRTY_DIRTY=2'b01, DIRTY_READ=2'b10, DIRTY_WR=2'b11 (shared with the tracker)
//   - FSM state encoding
// - No sub-module: single FSM plus Mask/Idx/data registers; linear scan kept inline.
// TESTING
// - N_REGS=8, Dirty_val reg2=01 and reg5=01, others 00, Nvm_ack same cycle, Ckpt_req:
//   -> Backup_en=8'h24; NVM writes to addr 2 then 5 with RF data; Backup_ack 8'h04 then 8'h20; Ckpt_done once.
// - All 00, Ckpt_req -> Backup_en=0; no Nvm_req; Ckpt_done 1+8+1 cycles after the request edge.
// - reg3=01; tracker reports 11 during first WR; Nvm_ack after 3 cycles:
//   -> two NVM writes to addr 3, the second with updated data; a single Backup_ack 8'h08.
// - Pwr_off asserted while Nvm_req is held for reg1:
//   -> Nvm_req low next cycle; Ckpt_abort pulse; no Backup_ack or Ckpt_done; Busy=0.
// - Ckpt_req pulsed again while Busy -> ignored; exactly one Ckpt_done; a new request after IDLE starts a fresh SNAP.
// - Rst_n low mid-WR -> all outputs 0 immediately (async); IDLE after release.

Source files
------------

// File: rtl/backup_pkg.sv
// Shared encodings for the checkpoint sequencer and the per-register dirty trackers.
package backup_pkg;

   typedef enum logic [1:0] {
      DIRTY_CLEAN = 2'b00,
      DIRTY_DIRTY = 2'b01,
      DIRTY_READ  = 2'b10,
      DIRTY_WR    = 2'b11
   } dirty_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SNAP,
      ST_SCAN,
      ST_RD,
      ST_WR,
      ST_ACK,
      ST_DONE
   } state_e;

endpackage

// File: rtl/backup_ctrl.sv
// Checkpoint sequencer: snapshots the dirty set, copies each dirty register to NVM, acks per register.
// Min 4 cycles per dirty register with same-cycle Nvm_ack; NVM request held until Nvm_ack; Pwr_off aborts.
module backup_ctrl
   import backup_pkg::*;
#(
   parameter int                N_REGS   = 8,
   parameter int                DATA_W   = 32,
   parameter int                NVM_AW   = 16,
   parameter logic [NVM_AW-1:0] NVM_BASE = '0,
   localparam int               IW       = $clog2(N_REGS)
) (
   input  logic                Clk,
   input  logic                Rst_n,
   input  logic                Ckpt_req,
   input  logic                Pwr_off,
   input  logic [2*N_REGS-1:0] Dirty_val,
   output logic [N_REGS-1:0]   Backup_en,
   output logic [N_REGS-1:0]   Backup_ack,
   output logic [IW-1:0]       Rf_rd_addr,
   input  logic [DATA_W-1:0]   Rf_rd_data,
   output logic                Nvm_req,
   output logic [NVM_AW-1:0]   Nvm_addr,
   output logic [DATA_W-1:0]   Nvm_wdata,
   input  logic                Nvm_ack,
   output logic                Busy,
   output logic                Ckpt_done,
   output logic                Ckpt_abort
);

   state_e              state_q, state_d;
   logic [N_REGS-1:0]   mask_q;
   logic [N_REGS-1:0]   snap_mask;
   logic [IW-1:0]       idx_q;
   logic                resaved_q;
   logic [DATA_W-1:0]   data_q;
   logic                abort_q;
   logic [1:0]          cur_code;
   logic                last_idx;
   logic                kill;

   always_comb begin
      for (int i = 0; i < N_REGS; i++) begin
         snap_mask[i] = (Dirty_val[2*i +: 2] == DIRTY_DIRTY);
      end
   end

   assign cur_code   = Dirty_val[2*idx_q +: 2];
   assign last_idx   = (idx_q == IW'(N_REGS - 1));
   assign kill       = (state_q != ST_IDLE) && Pwr_off;
   assign Busy       = (state_q != ST_IDLE);
   assign Ckpt_abort = abort_q;
   assign Rf_rd_addr = idx_q;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      Backup_en  = '0;
      Backup_ack = '0;
      Nvm_req    = 1'b0;
      Nvm_addr   = '0;
      Nvm_wdata  = '0;
      Ckpt_done  = 1'b0;
      case (state_q)
         ST_IDLE: if (Ckpt_req && !Pwr_off) state_d = ST_SNAP;
         ST_SNAP: begin
            Backup_en = snap_mask;
            state_d   = ST_SCAN;
         end
         ST_SCAN: begin
            if (mask_q[idx_q])  state_d = ST_RD;
            else if (last_idx)  state_d = ST_DONE;
         end
         ST_RD: state_d = ST_WR;
         ST_WR: begin
            Nvm_req   = 1'b1;
            Nvm_addr  = NVM_BASE + NVM_AW'(idx_q);
            Nvm_wdata = data_q;
            // A register written between its read and the NVM accept gets exactly one re-save.
            if (Nvm_ack) begin
               state_d = (cur_code == DIRTY_WR && !resaved_q) ? ST_RD : ST_ACK;
            end
         end
         ST_ACK: begin
            Backup_ack = N_REGS'(1) << idx_q;
            state_d    = last_idx ? ST_DONE : ST_SCAN;
         end
         ST_DONE: begin
            Ckpt_done = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (kill) state_d = ST_IDLE;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         mask_q    <= '0;
         idx_q     <= '0;
         resaved_q <= 1'b0;
         data_q    <= '0;
         abort_q   <= 1'b0;
      end else begin
         abort_q <= kill;
         if (kill) begin
            mask_q    <= '0;
            resaved_q <= 1'b0;
         end else begin
            case (state_q)
               ST_SNAP: begin
                  mask_q <= snap_mask;
                  idx_q  <= '0;
               end
               ST_SCAN: if (!mask_q[idx_q] && !last_idx) idx_q <= idx_q + IW'(1);
               ST_RD:   data_q <= Rf_rd_data;
               ST_WR:   if (Nvm_ack && cur_code == DIRTY_WR && !resaved_q) resaved_q <= 1'b1;
               ST_ACK: begin
                  mask_q[idx_q] <= 1'b0;
                  resaved_q     <= 1'b0;
                  if (!last_idx) idx_q <= idx_q + IW'(1);
               end
               default: ;
            endcase
         end
      end
   end

endmodule
